// File: rtl/sc_backgctrl_pkg.sv
// Shared types and constants for the background-type rotate register controller.
// State and shift-code encodings plus the period helper used by the scheduler.
package sc_backgctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_ROTATE = 3'd3,
    ST_LOAD   = 3'd4,
    ST_PAUSED = 3'd5
  } backgState_t;

  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_LEFT  = 2'b01,
    SHIFT_RIGHT = 2'b10
  } shiftCode_t;

  localparam int unsigned MIN_PERIOD = 2;

  // Very short periods would leave no RUN cycle between rotates, so clamp.
  function automatic logic [31:0] calcPeriod(input logic [31:0] base, input logic [1:0] speed);
    logic [31:0] shifted;
    shifted = base >> speed;
    return (shifted < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : shifted;
  endfunction

endpackage

// File: rtl/sc_backgctrl_if.sv
// Command/response bundle between the game FSM (master) and the scheduler (slave).
// Register-side outputs of the scheduler travel back on the same bundle.
interface sc_backgctrl_if #(
  parameter int DATAWIDTH = 4,
  parameter int STEPWIDTH = 8
);
  logic                 SC_BACKGCTRL_start_InLow;
  logic                 SC_BACKGCTRL_stop_InLow;
  logic                 SC_BACKGCTRL_pause_InLow;
  logic                 SC_BACKGCTRL_loadreq_InLow;
  logic [DATAWIDTH-1:0] SC_BACKGCTRL_pattern_InBUS;
  logic                 SC_BACKGCTRL_dir_In;
  logic [1:0]           SC_BACKGCTRL_speed_In;
  logic                 SC_BACKGCTRL_clear_OutLow;
  logic                 SC_BACKGCTRL_load_OutLow;
  logic [1:0]           SC_BACKGCTRL_shiftselection_Out;
  logic [DATAWIDTH-1:0] SC_BACKGCTRL_data_OutBUS;
  logic [STEPWIDTH-1:0] SC_BACKGCTRL_step_OutBUS;
  logic                 SC_BACKGCTRL_busy_Out;

  modport master (
    output SC_BACKGCTRL_start_InLow, SC_BACKGCTRL_stop_InLow, SC_BACKGCTRL_pause_InLow,
           SC_BACKGCTRL_loadreq_InLow, SC_BACKGCTRL_pattern_InBUS, SC_BACKGCTRL_dir_In,
           SC_BACKGCTRL_speed_In,
    input  SC_BACKGCTRL_clear_OutLow, SC_BACKGCTRL_load_OutLow, SC_BACKGCTRL_shiftselection_Out,
           SC_BACKGCTRL_data_OutBUS, SC_BACKGCTRL_step_OutBUS, SC_BACKGCTRL_busy_Out
  );

  modport slave (
    input  SC_BACKGCTRL_start_InLow, SC_BACKGCTRL_stop_InLow, SC_BACKGCTRL_pause_InLow,
           SC_BACKGCTRL_loadreq_InLow, SC_BACKGCTRL_pattern_InBUS, SC_BACKGCTRL_dir_In,
           SC_BACKGCTRL_speed_In,
    output SC_BACKGCTRL_clear_OutLow, SC_BACKGCTRL_load_OutLow, SC_BACKGCTRL_shiftselection_Out,
           SC_BACKGCTRL_data_OutBUS, SC_BACKGCTRL_step_OutBUS, SC_BACKGCTRL_busy_Out
  );
endinterface

// File: rtl/sc_backgctrl_prescaler.sv
// Rotate prescaler: counts enabled cycles and flags when the count reaches period-1.
// The flag uses >= so a period shortened mid-count still terminates on the next cycle.
module sc_backgctrl_prescaler #(
  parameter int CNT_WIDTH = 24
) (
  input  logic                 SC_BACKGCTRL_CLOCK_50,
  input  logic                 SC_BACKGCTRL_RESET_InHigh,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] period,
  output logic                 terminalCount
);

  logic [CNT_WIDTH-1:0] count;

  assign terminalCount = (count >= (period - CNT_WIDTH'(1)));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge SC_BACKGCTRL_CLOCK_50 or posedge SC_BACKGCTRL_RESET_InHigh) begin
    if (SC_BACKGCTRL_RESET_InHigh) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_backgctrl_scheduler.sv
// Sequencer for the background-type rotate register: start-clear, pattern load, pause, rotate.
// All register-side outputs are registered together with the state, so each is valid for the whole state cycle.
module sc_backgctrl_scheduler
  import sc_backgctrl_pkg::*;
#(
  parameter int                           BACKGCTRL_DATAWIDTH   = 4,
  parameter int                           BACKGCTRL_CNT_WIDTH   = 24,
  parameter logic [BACKGCTRL_CNT_WIDTH-1:0] BACKGCTRL_PERIOD_BASE = 24'd5000000,
  parameter int                           BACKGCTRL_STEP_WIDTH  = 8
) (
  input logic           SC_BACKGCTRL_CLOCK_50,
  input logic           SC_BACKGCTRL_RESET_InHigh,
  sc_backgctrl_if.slave bus
);

  backgState_t                     state;
  shiftCode_t                      shiftSel;
  logic                            clearN;
  logic                            loadN;
  logic                            busy;
  logic [BACKGCTRL_DATAWIDTH-1:0]  dataReg;
  logic [BACKGCTRL_STEP_WIDTH-1:0] stepCnt;

  logic [BACKGCTRL_CNT_WIDTH-1:0]  period;
  logic                            prescClear;
  logic                            prescEnable;
  logic                            terminalCount;
  logic                            runIdle;

  assign period = BACKGCTRL_CNT_WIDTH'(calcPeriod(32'(BACKGCTRL_PERIOD_BASE), bus.SC_BACKGCTRL_speed_In));

  // RUN with no higher-priority request pending: the only case where the prescaler advances.
  assign runIdle     = bus.SC_BACKGCTRL_stop_InLow & bus.SC_BACKGCTRL_loadreq_InLow &
                       bus.SC_BACKGCTRL_pause_InLow;
  assign prescClear  = (state == ST_IDLE) || (state == ST_CLEAR) ||
                       (state == ST_ROTATE) || (state == ST_LOAD);
  assign prescEnable = (state == ST_RUN) && runIdle && !terminalCount;

  sc_backgctrl_prescaler #(
    .CNT_WIDTH(BACKGCTRL_CNT_WIDTH)
  ) u_prescaler (
    .SC_BACKGCTRL_CLOCK_50    (SC_BACKGCTRL_CLOCK_50),
    .SC_BACKGCTRL_RESET_InHigh(SC_BACKGCTRL_RESET_InHigh),
    .clear                    (prescClear),
    .enable                   (prescEnable),
    .period                   (period),
    .terminalCount            (terminalCount)
  );

  always_ff @(posedge SC_BACKGCTRL_CLOCK_50 or posedge SC_BACKGCTRL_RESET_InHigh) begin
    if (SC_BACKGCTRL_RESET_InHigh) begin
      state    <= ST_IDLE;
      clearN   <= 1'b1;
      loadN    <= 1'b1;
      shiftSel <= SHIFT_NONE;
      dataReg  <= '0;
      stepCnt  <= '0;
      busy     <= 1'b0;
    end else begin
      // Command strobes last one cycle; only the branch entering a strobe state re-asserts one.
      clearN   <= 1'b1;
      loadN    <= 1'b1;
      shiftSel <= SHIFT_NONE;
      unique case (state)
        ST_IDLE: begin
          if (!bus.SC_BACKGCTRL_start_InLow) begin
            state   <= ST_CLEAR;
            clearN  <= 1'b0;
            stepCnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_CLEAR, ST_ROTATE, ST_LOAD: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (!bus.SC_BACKGCTRL_stop_InLow) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (!bus.SC_BACKGCTRL_loadreq_InLow) begin
            state   <= ST_LOAD;
            loadN   <= 1'b0;
            dataReg <= bus.SC_BACKGCTRL_pattern_InBUS;
          end else if (!bus.SC_BACKGCTRL_pause_InLow) begin
            state <= ST_PAUSED;
          end else if (terminalCount) begin
            state    <= ST_ROTATE;
            shiftSel <= bus.SC_BACKGCTRL_dir_In ? SHIFT_RIGHT : SHIFT_LEFT;
            stepCnt  <= stepCnt + BACKGCTRL_STEP_WIDTH'(1);
          end
        end
        ST_PAUSED: begin
          if (!bus.SC_BACKGCTRL_stop_InLow) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (bus.SC_BACKGCTRL_pause_InLow) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SC_BACKGCTRL_clear_OutLow       = clearN;
  assign bus.SC_BACKGCTRL_load_OutLow        = loadN;
  assign bus.SC_BACKGCTRL_shiftselection_Out = shiftSel;
  assign bus.SC_BACKGCTRL_data_OutBUS        = dataReg;
  assign bus.SC_BACKGCTRL_step_OutBUS        = stepCnt;
  assign bus.SC_BACKGCTRL_busy_Out           = busy;

endmodule
